// File: rtl/obstacle_avoid_ctrl_pkg.sv
// Shared types and constants for the obstacle-avoidance drive controller.
package obstacle_avoid_ctrl_pkg;

   typedef enum logic [2:0] {
      MANUAL = 3'd0,
      CRUISE = 3'd1,
      STOP   = 3'd2,
      BACKUP = 3'd3,
      ROTATE = 3'd4
   } state_t;

   // Direction bits are {up, down, left, right}
   localparam logic [3:0] DIR_FWD   = 4'b1000;
   localparam logic [3:0] DIR_REV   = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;
   localparam logic [3:0] DIR_IDLE  = 4'b0000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obstacle_avoid_ctrl_if.sv
// Sensor, operator and motor-command bundle of the avoidance controller.
interface obstacle_avoid_ctrl_if;

   logic [3:0]  key_dir;
   logic        auto_en;
   logic        dist_valid;
   logic [15:0] distance;
   logic        ping_busy;
   logic        ping_start;
   logic [3:0]  drive_dir;
   logic        blocked;
   logic        sensor_fault;
   logic [2:0]  state;

   modport master (
      output key_dir, auto_en, dist_valid, distance, ping_busy,
      input  ping_start, drive_dir, blocked, sensor_fault, state
   );

   modport slave (
      input  key_dir, auto_en, dist_valid, distance, ping_busy,
      output ping_start, drive_dir, blocked, sensor_fault, state
   );

endinterface

// File: rtl/obstacle_avoid_ctrl_ping_scheduler.sv
// Periodic ultrasonic ping request with reply timeout and range threshold.
module ping_scheduler
   import obstacle_avoid_ctrl_pkg::*;
#(
   parameter int PING_PERIOD  = 16,
   parameter int PING_TIMEOUT = 12,
   parameter int STOP_DIST    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ping_busy,
   input  logic        dist_valid,
   input  logic [15:0] distance,
   output logic        ping_start,
   output logic        blocked,
   output logic        sensor_fault
);

   localparam int PW = cnt_w(PING_PERIOD);
   localparam int TW = cnt_w(PING_TIMEOUT);
   localparam logic [PW-1:0] P_LAST = PW'(PING_PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(PING_TIMEOUT - 1);

   logic [PW-1:0] per_cnt;
   logic [TW-1:0] to_cnt;
   logic          outstanding;
   logic          at_end;
   logic          fire;
   logic          timeout;

   assign at_end  = (per_cnt == P_LAST);
   assign fire    = at_end & ~ping_busy & ~outstanding;
   assign timeout = outstanding & (to_cnt == T_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         per_cnt      <= '0;
         to_cnt       <= '0;
         outstanding  <= 1'b0;
         ping_start   <= 1'b0;
         blocked      <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         ping_start <= fire;
         // Counter parks on its last value while the ranger is busy
         if (fire)
            per_cnt <= '0;
         else if (!at_end)
            per_cnt <= per_cnt + 1'b1;
         if (dist_valid)
            blocked <= (distance < 16'(STOP_DIST));
         if (outstanding)
            to_cnt <= to_cnt + 1'b1;
         if (outstanding && dist_valid) begin
            outstanding  <= 1'b0;
            sensor_fault <= 1'b0;
         end else if (timeout) begin
            outstanding  <= 1'b0;
            sensor_fault <= 1'b1;
         end
         if (fire) begin
            outstanding <= 1'b1;
            to_cnt      <= '0;
         end
      end
   end

endmodule

// File: rtl/obstacle_avoid_ctrl.sv
// Manual/autonomous drive FSM with stop-backup-rotate obstacle avoidance.
// OBSTACLE_AVOID_ALT_ROTATE_EN: alternate rotate right/left per avoidance.
module obstacle_avoid_ctrl
   import obstacle_avoid_ctrl_pkg::*;
#(
   parameter int PING_PERIOD  = 16,
   parameter int PING_TIMEOUT = 12,
   parameter int STOP_DIST    = 3,
   parameter int HOLD_CYC     = 4,
   parameter int REVERSE_CYC  = 8,
   parameter int ROTATE_CYC   = 6
) (
   input  logic           clk,
   input  logic           reset,
   obstacle_avoid_ctrl_if.slave bus
);

   localparam int PH_W = cnt_w(max3(HOLD_CYC, REVERSE_CYC, ROTATE_CYC));
   localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYC - 1);
   localparam logic [PH_W-1:0] REV_LAST  = PH_W'(REVERSE_CYC - 1);
   localparam logic [PH_W-1:0] ROT_LAST  = PH_W'(ROTATE_CYC - 1);

   state_t          st;
   logic [3:0]      drive;
   logic [PH_W-1:0] phase;
   logic [3:0]      man_dir;
   logic [3:0]      rot_dir;
   logic            blocked;
   logic            ping_start;
   logic            sensor_fault;

   ping_scheduler #(
      .PING_PERIOD  (PING_PERIOD),
      .PING_TIMEOUT (PING_TIMEOUT),
      .STOP_DIST    (STOP_DIST)
   ) u_ping (
      .clk          (clk),
      .reset        (reset),
      .ping_busy    (bus.ping_busy),
      .dist_valid   (bus.dist_valid),
      .distance     (bus.distance),
      .ping_start   (ping_start),
      .blocked      (blocked),
      .sensor_fault (sensor_fault)
   );

   assign man_dir = {bus.key_dir[3] & ~blocked, bus.key_dir[2:0]};

`ifdef OBSTACLE_AVOID_ALT_ROTATE_EN
   logic rot_left;
   logic rot_exit;

   assign rot_exit = bus.auto_en & (st == ROTATE) & (phase == ROT_LAST);
   assign rot_dir  = rot_left ? DIR_LEFT : DIR_RIGHT;

   always_ff @(posedge clk) begin
      if (reset)
         rot_left <= 1'b0;
      else if (rot_exit)
         rot_left <= ~rot_left;
   end
`else
   assign rot_dir = DIR_RIGHT;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= MANUAL;
         drive <= DIR_IDLE;
         phase <= '0;
      end else if (!bus.auto_en) begin
         st    <= MANUAL;
         drive <= man_dir;
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
         unique case (st)
            MANUAL: begin
               st    <= CRUISE;
               drive <= DIR_FWD;
               phase <= '0;
            end
            CRUISE: begin
               phase <= '0;
               if (blocked) begin
                  st    <= STOP;
                  drive <= DIR_IDLE;
               end else begin
                  drive <= DIR_FWD;
               end
            end
            STOP: begin
               drive <= DIR_IDLE;
               if (phase == HOLD_LAST) begin
                  st    <= BACKUP;
                  drive <= DIR_REV;
                  phase <= '0;
               end
            end
            BACKUP: begin
               drive <= DIR_REV;
               if (phase == REV_LAST) begin
                  st    <= ROTATE;
                  drive <= rot_dir;
                  phase <= '0;
               end
            end
            ROTATE: begin
               drive <= rot_dir;
               // Only the range seen at exit decides: resume or go again
               if (phase == ROT_LAST) begin
                  phase <= '0;
                  st    <= blocked ? STOP : CRUISE;
                  drive <= blocked ? DIR_IDLE : DIR_FWD;
               end
            end
            default: begin
               st    <= MANUAL;
               drive <= DIR_IDLE;
               phase <= '0;
            end
         endcase
      end
   end

   assign bus.state        = st;
   assign bus.drive_dir    = drive;
   assign bus.blocked      = blocked;
   assign bus.ping_start   = ping_start;
   assign bus.sensor_fault = sensor_fault;

endmodule

// File: tb/tb_obstacle_avoid_ctrl.sv
// Directed bench for obstacle_avoid_ctrl at default parameters.
module tb_obstacle_avoid_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   localparam logic [2:0] S_MAN  = 3'd0;
   localparam logic [2:0] S_CRU  = 3'd1;
   localparam logic [2:0] S_STOP = 3'd2;
   localparam logic [2:0] S_BACK = 3'd3;
   localparam logic [2:0] S_ROT  = 3'd4;
   localparam logic [3:0] R1 = 4'b0001;
`ifdef OBSTACLE_AVOID_ALT_ROTATE_EN
   localparam logic [3:0] R2 = 4'b0010;
`else
   localparam logic [3:0] R2 = 4'b0001;
`endif

   obstacle_avoid_ctrl_if bus();

   obstacle_avoid_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk);
      reset          = 1'b1;
      bus.auto_en    = 1'b0;
      bus.key_dir    = 4'b0000;
      bus.dist_valid = 1'b0;
      bus.distance   = 16'd0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_dist(input logic [15:0] d);
      @(negedge clk);
      bus.dist_valid = 1'b1;
      bus.distance   = d;
      @(negedge clk);
      bus.dist_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.ping_busy = 1'b0;
      apply_reset();
      n_chk++;
      if (bus.state !== S_MAN) begin
         n_fail++;
         $display("FAIL reset_state got %0d want %0d", bus.state, S_MAN);
      end
      n_chk++;
      if (bus.drive_dir !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_drive got %b want 0000", bus.drive_dir);
      end
      n_chk++;
      if ({bus.ping_start, bus.blocked, bus.sensor_fault} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 000",
                  {bus.ping_start, bus.blocked, bus.sensor_fault});
      end
   endtask

   // Continues straight after test_reset: k counts edges since release
   task automatic test_ping();
      logic ep, ef, eb;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         ep = (k == 16) || (k == 32) || (k == 48) || (k == 64);
         ef = (k >= 28) && (k <= 34);
         eb = ((k >= 35) && (k <= 40)) || (k >= 60);
         n_chk++;
         if (bus.ping_start !== ep) begin
            n_fail++;
            $display("FAIL ping_start k=%0d got %b want %b", k, bus.ping_start, ep);
         end
         n_chk++;
         if (bus.sensor_fault !== ef) begin
            n_fail++;
            $display("FAIL sensor_fault k=%0d got %b want %b", k, bus.sensor_fault, ef);
         end
         n_chk++;
         if (bus.blocked !== eb) begin
            n_fail++;
            $display("FAIL blocked k=%0d got %b want %b", k, bus.blocked, eb);
         end
         bus.dist_valid = (k == 34) || (k == 40) || (k == 59);
         bus.distance = (k == 34) ? 16'd1 : (k == 40) ? 16'd3 : 16'd0;
      end
      bus.dist_valid = 1'b0;
   endtask

   task automatic test_manual();
      logic [15:0] dv [4];
      logic [3:0]  kv [4];
      logic [3:0]  ed [4];
      logic        eb [4];
      dv = '{16'd2, 16'd3, 16'd0, 16'hFFFF};
      kv = '{4'b1000, 4'b1000, 4'b1011, 4'b1011};
      ed = '{4'b0000, 4'b1000, 4'b0011, 4'b1011};
      eb = '{1'b1, 1'b0, 1'b1, 1'b0};
      bus.auto_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.key_dir = kv[i];
         pulse_dist(dv[i]);
         @(negedge clk);
         n_chk++;
         if (bus.blocked !== eb[i]) begin
            n_fail++;
            $display("FAIL man_blocked i=%0d got %b want %b", i, bus.blocked, eb[i]);
         end
         n_chk++;
         if (bus.drive_dir !== ed[i]) begin
            n_fail++;
            $display("FAIL man_drive i=%0d got %b want %b", i, bus.drive_dir, ed[i]);
         end
      end
   endtask

   task automatic run_seq(input bit clr, input logic [3:0] rot);
      logic [2:0] es;
      logic [3:0] ed;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         es = (i < 4) ? S_STOP : (i < 12) ? S_BACK : S_ROT;
         ed = (i < 4) ? 4'b0000 : (i < 12) ? 4'b0100 : rot;
         n_chk++;
         if (bus.state !== es) begin
            n_fail++;
            $display("FAIL seq_state i=%0d got %0d want %0d", i, bus.state, es);
         end
         n_chk++;
         if (bus.drive_dir !== ed) begin
            n_fail++;
            $display("FAIL seq_drive i=%0d got %b want %b", i, bus.drive_dir, ed);
         end
         bus.dist_valid = clr && (i == 2);
         bus.distance   = 16'd50;
      end
   endtask

   task automatic test_avoid();
      bus.ping_busy = 1'b0;
      apply_reset();
      bus.auto_en = 1'b1;
      bus.key_dir = 4'b0100;
      @(negedge clk);
      n_chk++;
      if (bus.state !== S_CRU || bus.drive_dir !== 4'b1000) begin
         n_fail++;
         $display("FAIL cruise_entry got %0d/%b want 1/1000", bus.state, bus.drive_dir);
      end
      pulse_dist(16'd2);
      n_chk++;
      if (bus.state !== S_CRU || bus.blocked !== 1'b1) begin
         n_fail++;
         $display("FAIL cruise_blocked got %0d/%b want 1/1", bus.state, bus.blocked);
      end
      run_seq(1'b0, R1);
      run_seq(1'b1, R2);
      @(negedge clk);
      n_chk++;
      if (bus.state !== S_CRU || bus.drive_dir !== 4'b1000) begin
         n_fail++;
         $display("FAIL resume_cruise got %0d/%b want 1/1000", bus.state, bus.drive_dir);
      end
   endtask

   task automatic test_abort();
      bus.ping_busy = 1'b0;
      apply_reset();
      bus.auto_en = 1'b1;
      @(negedge clk);
      pulse_dist(16'd2);
      for (int i = 0; i < 6; i++) @(negedge clk);
      n_chk++;
      if (bus.state !== S_BACK) begin
         n_fail++;
         $display("FAIL abort_pre got %0d want %0d", bus.state, S_BACK);
      end
      bus.key_dir = 4'b0011;
      bus.auto_en = 1'b0;
      @(negedge clk);
      n_chk++;
      if (bus.state !== S_MAN || bus.drive_dir !== 4'b0011) begin
         n_fail++;
         $display("FAIL abort_manual got %0d/%b want 0/0011", bus.state, bus.drive_dir);
      end
      bus.auto_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 14; i++) @(negedge clk);
      n_chk++;
      if (bus.state !== S_ROT) begin
         n_fail++;
         $display("FAIL abort_rotate got %0d want %0d", bus.state, S_ROT);
      end
      reset = 1'b1;
      bus.auto_en = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({bus.state, bus.drive_dir, bus.ping_start, bus.blocked,
           bus.sensor_fault} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_rotate got %0d/%b/%b%b%b want all 0", bus.state,
                  bus.drive_dir, bus.ping_start, bus.blocked, bus.sensor_fault);
      end
      reset = 1'b0;
   endtask

   task automatic test_busy();
      logic ep, ef;
      bus.ping_busy = 1'b1;
      apply_reset();
      for (int k = 1; k <= 42; k++) begin
         @(negedge clk);
         ep = (k == 26) || (k == 42);
         ef = (k >= 38);
         n_chk++;
         if (bus.ping_start !== ep) begin
            n_fail++;
            $display("FAIL busy_ping k=%0d got %b want %b", k, bus.ping_start, ep);
         end
         n_chk++;
         if (bus.sensor_fault !== ef) begin
            n_fail++;
            $display("FAIL busy_fault k=%0d got %b want %b", k, bus.sensor_fault, ef);
         end
         if (k == 25) bus.ping_busy = 1'b0;
      end
   endtask

   initial begin
      bus.key_dir    = 4'b0000;
      bus.auto_en    = 1'b0;
      bus.dist_valid = 1'b0;
      bus.distance   = 16'd0;
      bus.ping_busy  = 1'b0;
      test_reset();
      test_ping();
      test_manual();
      test_avoid();
      test_abort();
      test_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/obstacle_avoid_ctrl.md
OBSTACLE_AVOID_CTRL -- requirements
Module: obstacle_avoid_ctrl

Interface
REQ-001 Parameters SHALL be provided as follows.
- PING_PERIOD, 16, cycles between ultrasonic ping requests.
- PING_TIMEOUT, 12, cycles to wait for `dist_valid` after a ping.
- STOP_DIST, 3, obstacle threshold in cm; blocked when distance < STOP_DIST.
- HOLD_CYC, 4, cycles spent in STOP.
- REVERSE_CYC, 8, cycles spent in BACKUP.
- ROTATE_CYC, 6, cycles spent in ROTATE.

REQ-002 Ports SHALL be provided as follows; one clock, synchronous active-high reset.
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- key_dir  in  4  manual request {up,down,left,right}, active-high level.
- auto_en  in  1  1 = autonomous mode, 0 = manual mode.
- dist_valid  in  1  one-cycle pulse; `distance` is valid.
- distance  in  16  measured range in cm, unsigned.
- ping_busy  in  1  rangefinder currently measuring.
- ping_start  out  1  one-cycle ping request.
- drive_dir  out  4  command {up,down,left,right} to the motor control block.
- blocked  out  1  registered: last valid range was < STOP_DIST.
- sensor_fault  out  1  last ping timed out.
- state  out  3  FSM state encoding, for HEX display.

Function
REQ-003 The FSM SHALL have states MANUAL=0, CRUISE=1, STOP=2, BACKUP=3, ROTATE=4; all outputs SHALL be registered.
REQ-004 A ping scheduler counter SHALL run independently of the FSM and behave as follows.
- When it reaches PING_PERIOD-1 with ping_busy=0 and no ping outstanding, it SHALL pulse ping_start for exactly 1 cycle, set an outstanding flag and restart.
- If ping_busy=1 at that point, it SHALL hold at PING_PERIOD-1 until ping_busy=0.
REQ-005 While a ping is outstanding, the first dist_valid SHALL have the following effect.
- It SHALL clear the outstanding flag and sensor_fault.
- It SHALL set blocked = (distance < STOP_DIST) on the next cycle.
REQ-006 If dist_valid does not arrive within PING_TIMEOUT cycles of ping_start, the timeout SHALL have the following effect.
- The outstanding flag SHALL clear and sensor_fault SHALL set.
- blocked SHALL be left unchanged.
- A dist_valid arriving on the timeout cycle SHALL win.
REQ-007 A dist_valid with no ping outstanding SHALL still update blocked.
REQ-008 In MANUAL, drive_dir SHALL equal key_dir, except that the up bit SHALL be forced to 0 while blocked=1.
REQ-009 MANUAL SHALL go to CRUISE when auto_en=1; every other state SHALL go to MANUAL on the cycle after auto_en=0, aborting any sequence.
REQ-010 In CRUISE, drive_dir SHALL be 4'b1000 and key_dir SHALL be ignored; CRUISE SHALL go to STOP on the cycle after blocked rises.
REQ-011 The avoidance states SHALL sequence as follows.
- STOP SHALL drive 4'b0000 for HOLD_CYC cycles, then go to BACKUP.
- BACKUP SHALL drive 4'b0100 for REVERSE_CYC cycles, then go to ROTATE.
- ROTATE SHALL drive the rotate direction (REQ-017) for ROTATE_CYC cycles.
REQ-012 A single phase counter sized for max(HOLD_CYC, REVERSE_CYC, ROTATE_CYC) SHALL run as follows.
- It SHALL clear on every state entry.
- The state SHALL exit when the counter equals the phase length minus 1.
REQ-013 On ROTATE exit, the FSM SHALL go to CRUISE if blocked=0, and SHALL re-enter STOP if blocked=1.
REQ-014 blocked changes during STOP/BACKUP/ROTATE SHALL NOT alter the sequence.
REQ-015 Distance comparison SHALL be unsigned over the full 16 bits; distance=STOP_DIST SHALL count as clear.

Reset
REQ-016 On reset, the block SHALL take the following values.
- state=MANUAL, drive_dir=0, ping_start=0, blocked=0, sensor_fault=0.
- Ping counter, phase counter and outstanding flag SHALL clear.
- A reset mid-sequence SHALL abandon the sequence.
- The first ping SHALL occur PING_PERIOD cycles after reset deasserts.

Configuration
REQ-017 Macro OBSTACLE_AVOID_ALT_ROTATE_EN SHALL select the rotate direction.
- Defined: ROTATE SHALL alternate between right (4'b0001) and left (4'b0010) on successive avoidances, starting right. The toggle register SHALL clear on reset.
- Undefined: ROTATE SHALL always drive 4'b0001.

Structure
REQ-018 A shared package SHALL hold the state enum and the direction constants DIR_FWD, DIR_REV, DIR_LEFT, DIR_RIGHT and DIR_IDLE.
REQ-019 The ping scheduler with its timeout SHALL be a sub-module named ping_scheduler; the FSM SHALL stay in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios (default parameters).
- Reset, ping_busy=0, no dist_valid: ping_start at cycle 16 after reset; sensor_fault=1 at cycle 28; next ping at cycle 32.
- auto_en=1, distance=2 valid: state sequence CRUISE to STOP (4 cycles, 0000), BACKUP (8 cycles, 0100), ROTATE (6 cycles, 0001); then CRUISE if distance=50 was received meanwhile.
- Manual mode, key_dir=1000, distance=2 then distance=3: drive_dir=0000 then 1000.
- auto_en dropped during BACKUP: MANUAL on the next cycle and drive_dir=key_dir; reset in ROTATE gives all outputs 0.
- ping_busy held high over the period: ping_start delayed until 1 cycle after ping_busy falls; never two ping_start pulses while outstanding.
- With OBSTACLE_AVOID_ALT_ROTATE_EN, two consecutive avoidances: ROTATE drives 0001, then 0010.
